dm_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 (pipeline M stage) and port 1 (debug/loader bridge).
- Arbitrates between them, latches the winning request, and drives the DM control and data ports for exactly one access cycle.
- Returns registered read data plus an ack/err pulse to the owner.
- Sits between the M-stage and loader logic on one side and the DM on the other. The M stage stalls while its req is high and ack is low.

---
 rtl/dm_arbiter.sv | 128 ++++++++++++
 tb/tb_dm_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the M stage (port 0) and the loader bridge (port 1).
// One latched access cycle per grant; ack/err/rdata are returned to the owner in the following cycle.
module dm_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned DM_BYTES   = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  wop0,
    input  logic [1:0]  wop1,
    input  logic [2:0]  rop0,
    input  logic [2:0]  rop1,
    input  logic [31:0] pc0,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] dm_pc,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wd,
    output logic [1:0]  dm_wop,
    output logic [2:0]  dm_rop,
    input  logic [31:0] dm_rd
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e      state_q, state_d;
    logic        own_q, own_d, ptr_q, ptr_d;
    logic        we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wd_q, wd_d, pc_q, pc_d, rdata_q, rdata_d;
    logic [1:0]  wop_q, wop_d;
    logic [2:0]  rop_q, rop_d;
    logic        el0, el1, win, in_rng, acc, rsp;
    logic [31:0] off;

    // In RESP the owner's req is still high for the finished access, so only the other port may bid.
    assign el0 = req0 & ((state_q == IDLE) | ((state_q == RESP) & own_q));
    assign el1 = req1 & ((state_q == IDLE) | ((state_q == RESP) & ~own_q));
    assign win = (el0 & el1) ? (FIXED_PRIO ? 1'b0 : ptr_q) : el1;
    assign off = addr_q - ADDR_BASE;
    assign in_rng = (addr_q >= ADDR_BASE) && (off < 32'(DM_BYTES));

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        wop_d   = wop_q;
        rop_d   = rop_q;
        pc_d    = pc_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (state_q == ACCESS) begin
            state_d = RESP;
            rdata_d = (in_rng && !we_q) ? dm_rd : 32'h0;
            err_d   = ~in_rng;
        end else if (el0 | el1) begin
            state_d = ACCESS;
            own_d   = win;
            ptr_d   = FIXED_PRIO ? ptr_q : ~win;
            we_d    = win ? we1 : we0;
            addr_d  = win ? addr1 : addr0;
            wd_d    = win ? wdata1 : wdata0;
            wop_d   = win ? wop1 : wop0;
            rop_d   = win ? rop1 : rop0;
            pc_d    = win ? 32'h0 : pc0;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            own_q   <= 1'b0;
            ptr_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            wop_q   <= 2'h0;
            rop_q   <= 3'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            wop_q   <= wop_d;
            rop_q   <= rop_d;
            pc_q    <= pc_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign acc     = (state_q == ACCESS);
    assign rsp     = (state_q == RESP);
    assign dm_we   = acc & we_q & in_rng;
    assign dm_addr = acc ? addr_q : 32'h0;
    assign dm_wd   = acc ? wd_q : 32'h0;
    assign dm_wop  = acc ? wop_q : 2'h0;
    assign dm_rop  = acc ? rop_q : 3'h0;
    assign dm_pc   = acc ? pc_q : 32'h0;
    assign ack0    = rsp & ~own_q;
    assign ack1    = rsp & own_q;
    assign err0    = ack0 & err_q;
    assign err1    = ack1 & err_q;
    assign rdata0  = ack0 ? rdata_q : 32'h0;
    assign rdata1  = ack1 ? rdata_q : 32'h0;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a behavioural byte-lane DM model.
// A second instance with FIXED_PRIO=1 answers loads with an address-derived pattern.
module tb_dm_arbiter;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, pc0 = 0;
    logic [1:0]  wop0 = 0, wop1 = 0;
    logic [2:0]  rop0 = 0, rop1 = 0;
    logic        ack0, ack1, err0, err1, dm_we;
    logic [31:0] rdata0, rdata1, dm_pc, dm_addr, dm_wd, dm_rd;
    logic [1:0]  dm_wop;
    logic [2:0]  dm_rop;
    logic        f_req0 = 0, f_req1 = 0;
    logic        f_ack0, f_ack1, f_err0, f_err1, f_dm_we;
    logic [31:0] f_rdata0, f_rdata1, f_dm_pc, f_dm_addr, f_dm_wd, f_dm_rd;
    logic [1:0]  f_dm_wop;
    logic [2:0]  f_dm_rop;
    logic [31:0] mem [0:4095];
    int          n_chk = 0, n_fail = 0;

    typedef struct packed {logic port; logic err; logic [31:0] rdata;} exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dm_arbiter u_rr (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .wop0(wop0), .wop1(wop1), .rop0(rop0), .rop1(rop1), .pc0(pc0),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .dm_pc(dm_pc), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd),
        .dm_wop(dm_wop), .dm_rop(dm_rop), .dm_rd(dm_rd)
    );

    dm_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset), .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
        .addr0(32'h100), .addr1(32'h200), .wdata0(32'h0), .wdata1(32'h0),
        .wop0(2'h0), .wop1(2'h0), .rop0(3'h0), .rop1(3'h0), .pc0(32'h0),
        .ack0(f_ack0), .ack1(f_ack1), .err0(f_err0), .err1(f_err1), .rdata0(f_rdata0), .rdata1(f_rdata1),
        .dm_pc(f_dm_pc), .dm_we(f_dm_we), .dm_addr(f_dm_addr), .dm_wd(f_dm_wd),
        .dm_wop(f_dm_wop), .dm_rop(f_dm_rop), .dm_rd(f_dm_rd)
    );

    assign f_dm_rd = f_dm_addr ^ 32'hA5A5_0000;

    function automatic logic [31:0] dm_read(input logic [31:0] w, input logic [1:0] a, input logic [2:0] rop);
        logic [15:0] h;
        logic [7:0]  b;
        h = a[1] ? w[31:16] : w[15:0];
        b = w[{a, 3'b000} +: 8];
        return rop == 3'd0 ? w : rop == 3'd1 ? {{16{h[15]}}, h} : rop == 3'd2 ? {{24{b[7]}}, b} : 32'h0;
    endfunction

    assign dm_rd = dm_read(mem[dm_addr[13:2]], dm_addr[1:0], dm_rop);

    always @(posedge clk) begin
        if (dm_we) begin
            if (dm_wop == 2'd1) mem[dm_addr[13:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_wd[15:0];
            else if (dm_wop == 2'd2) mem[dm_addr[13:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wd[7:0];
            else mem[dm_addr[13:2]] <= dm_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ack0 || ack1) begin
                exp_t e;
                check("ack_onehot", 32'(ack0 & ack1), 32'd0);
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_port", 32'(ack1), 32'(e.port));
                    check("sb_err", 32'(ack1 ? err1 : err0), 32'(e.err));
                    check("sb_rdata", ack1 ? rdata1 : rdata0, e.rdata);
                    check("other_quiet", (ack1 ? rdata0 : rdata1) | 32'(ack1 ? err0 : err1), 32'd0);
                end
            end else begin
                check("noack_quiet", rdata0 | rdata1 | 32'({err1, err0}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] wop, input logic [2:0] rop,
                          input logic [31:0] exp_rd, input bit exp_err);
        if (p) begin
            req1 = 1; we1 = we; addr1 = a; wdata1 = wd; wop1 = wop; rop1 = rop;
        end else begin
            req0 = 1; we0 = we; addr0 = a; wdata0 = wd; wop0 = wop; rop0 = rop; pc0 = 32'hC0DE_0000 ^ a;
        end
        sb.push_back(exp_t'{p, exp_err, exp_rd});
        tick();
        @(negedge clk);
        check("acc_we", 32'(dm_we), 32'(we & !exp_err));
        check("acc_addr", dm_addr, a);
        check("acc_wd", dm_wd, wd);
        check("acc_ctl", 32'({dm_wop, dm_rop}), 32'({wop, rop}));
        check("acc_pc", dm_pc, p ? 32'h0 : 32'hC0DE_0000 ^ a);
        check("acc_noack", 32'({ack1, ack0}), 32'd0);
        tick();
        @(negedge clk);
        check("ack_t2", 32'({ack1, ack0}), p ? 32'd2 : 32'd1);
        check("resp_no_we", 32'(dm_we), 32'd0);
        if (p) req1 = 0; else req0 = 0;
        tick();
    endtask

    task automatic both(input bit first, input int n);
        bit p;
        req0 = 1; we0 = 0; addr0 = 32'h10; rop0 = 3'd0;
        req1 = 1; we1 = 0; addr1 = 32'h20; rop1 = 3'd0;
        for (int k = 0; k < n; k++) begin
            p = first ^ k[0];
            sb.push_back(exp_t'{p, 1'b0, p ? 32'h1234_5678 : 32'hDEAD_BEEF});
        end
        for (int k = 0; k < n; k++) begin
            p = first ^ k[0];
            tick();
            tick();
            @(negedge clk);
            check("rr_ack", 32'({ack1, ack0}), p ? 32'd2 : 32'd1);
            if (k >= n - 2) begin
                if (p) req1 = 0; else req0 = 0;
            end
        end
        tick();
    endtask

    task automatic fp_test();
        bit p;
        f_req0 = 1;
        tick();
        tick();
        @(negedge clk);
        check("fp_solo_ack", 32'({f_ack1, f_ack0}), 32'd1);
        f_req0 = 0;
        tick();
        f_req0 = 1;
        f_req1 = 1;
        for (int k = 0; k < 4; k++) begin
            p = k[0];
            tick();
            tick();
            @(negedge clk);
            check("fp_ack", 32'({f_ack1, f_ack0}), p ? 32'd2 : 32'd1);
            check("fp_rdata", p ? f_rdata1 : f_rdata0, p ? 32'hA5A5_0200 : 32'hA5A5_0100);
            check("fp_err", 32'({f_err1, f_err0}), 32'd0);
            if (k >= 2) begin
                if (p) f_req1 = 0; else f_req0 = 0;
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[0]    = 32'h0BAD_F00D;
        mem[8]    = 32'h1234_5678;
        mem[4095] = 32'h600D_CAFE;
        repeat (3) tick();
        reset = 0;
        @(negedge clk);
        check("rst_flags", 32'({ack1, ack0, err1, err0, dm_we}), 32'd0);
        check("rst_rdata", rdata0 | rdata1, 32'd0);
        check("rst_dm", dm_addr | dm_wd | dm_pc | 32'({dm_wop, dm_rop}), 32'd0);
        tick();
        single(0, 1, 32'h10, 32'hDEAD_BEEF, 2'd0, 3'd0, 32'h0, 0);
        single(0, 0, 32'h10, 32'h0, 2'd0, 3'd0, 32'hDEAD_BEEF, 0);
        single(0, 0, 32'h13, 32'h0, 2'd0, 3'd2, 32'hFFFF_FFDE, 0);
        single(0, 0, 32'h12, 32'h0, 2'd0, 3'd1, 32'hFFFF_DEAD, 0);
        single(0, 0, 32'h10, 32'h0, 2'd0, 3'd3, 32'h0, 0);
        single(1, 1, 32'h4000, 32'hCAFE_F00D, 2'd0, 3'd0, 32'h0, 1);
        single(1, 0, 32'h3FFC, 32'h0, 2'd0, 3'd0, 32'h600D_CAFE, 0);
        both(0, 2);
        both(0, 4);
        single(0, 0, 32'h0, 32'h0, 2'd0, 3'd0, 32'h0BAD_F00D, 0);
        both(1, 2);
        fp_test();
        req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'h55; wop0 = 2'd0; rop0 = 3'd0;
        tick();
        @(negedge clk);
        check("rst_acc_we", 32'(dm_we), 32'd1);
        reset = 1;
        req0 = 0;
        tick();
        reset = 0;
        @(negedge clk);
        check("rst_drop_ack", 32'({ack1, ack0, err1, err0, dm_we}), 32'd0);
        check("rst_drop_dm", dm_addr | dm_wd | rdata0, 32'd0);
        tick();
        single(0, 0, 32'h10, 32'h0, 2'd0, 3'd0, 32'hDEAD_BEEF, 0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
